assert_violation_collector: RTL and testbench
=============================================

# assert_violation_collector

Aggregates the qualified `out` signals of up to `NUM_CHK` fabric assertion checkers into one latched violation report and a level interrupt to the host processor. It sits directly downstream of the checker array. It records which checker fired first, counts violating cycles and flags reports lost while one is pending. It also masks checker outputs for a fixed hold-off window after every fabric reconfiguration, so that stale checker state cannot raise spurious interrupts.

## Interface
Parameters:
- `NUM_CHK`, 8, number of checker inputs (≥1)
- `ID_W`, 3, width of checker index; must satisfy 2^ID_W ≥ NUM_CHK
- `CNT_W`, 8, width of the saturating violation counter
- `HOLDOFF_CYC`, 4, hold-off length in cycles after reset or reconfiguration (1..255)

Ports:
- `clk`  in  1  single clock; all logic on its rising edge
- `rst`  in  1  synchronous, active-low reset (0 = reset)
- `chk_fire`  in  NUM_CHK  qualified checker outputs, bit i = checker i
- `chk_mask`  in  NUM_CHK  1 = ignore checker i
- `cfg_update`  in  1  one-cycle pulse: fabric configuration reloaded
- `irq_ack`  in  1  host acknowledge; honoured only while `irq` = 1
- `irq`  out  1  violation pending, level
- `vio_id`  out  ID_W  index of the lowest-numbered checker in the captured report
- `vio_vec`  out  NUM_CHK  effective fire vector at capture
- `vio_count`  out  CNT_W  saturating count of violating cycles
- `vio_lost`  out  1  sticky flag: violation occurred while a report was pending
- `armed`  out  1  1 when in ARMED

## Operation
- `eff = chk_fire & ~chk_mask`; a violation cycle is any cycle with `eff != 0`.
- FSM states: HOLD, ARMED, PEND. Internal hold-off counter `ho_cnt` is 8 bits. Internal flag `ho_req`.
- Reset (`rst` = 0 at an edge):
  - state = HOLD, `ho_cnt` = HOLDOFF_CYC, `ho_req` = 0.
  - `irq`, `vio_id`, `vio_vec`, `vio_count`, `vio_lost` and `armed` all = 0.
- HOLD:
  - `eff` is ignored entirely: no count, no capture.
  - `ho_cnt` decrements each cycle. When `ho_cnt` = 1, the next state is ARMED.
  - `cfg_update` in HOLD reloads `ho_cnt` = HOLDOFF_CYC.
- ARMED:
  - If `cfg_update` = 1: go to HOLD and reload `ho_cnt`. `eff` in the same cycle is ignored (reconfiguration wins).
  - Else if `eff != 0`:
    - capture `vio_vec` = `eff` and `vio_id` = index of the lowest set bit of `eff`;
    - increment `vio_count`;
    - set `irq` = 1 and go to PEND.
- PEND:
  - `eff != 0` increments `vio_count` and sets `vio_lost` = 1. `vio_vec` and `vio_id` are not modified.
  - `cfg_update` sets `ho_req` = 1 and stays in PEND, so the report is preserved.
  - `irq_ack` = 1:
    - `irq` = 0 and `vio_lost` = 0;
    - next state is HOLD (reload `ho_cnt`) if `ho_req` is set or `cfg_update` = 1 in this cycle, otherwise ARMED;
    - `ho_req` clears.
  - `irq_ack` together with `eff != 0` in the same cycle: the cycle is counted, and `vio_lost` is set = 1 (set wins over clear).
- `irq_ack` outside PEND has no effect.
- `vio_count` saturates at 2^CNT_W−1 and is cleared only by reset.
- `vio_id` and `vio_vec` hold their value until the next capture.

## Timing
- All outputs are registered. Violation in ARMED at edge N → `irq`, `vio_id` and `vio_vec` valid after edge N, i.e. 1-cycle latency.
- `armed` is registered state decode: 0 during the HOLD_CYC cycles after reset.
- After release of reset, the first cycle where a fire can be captured is cycle HOLDOFF_CYC (0-based from the first non-reset edge).
- Ack at edge M → `irq` = 0 after edge M. A fire at edge M+1 can then be captured, unless the ack sent the FSM to HOLD.
- Reset asserted mid-PEND: `irq` drops at that edge, and all report state clears.

## Test plan
- Hold-off: HOLDOFF_CYC = 4, `chk_fire` = 0xFF held from release of reset → `irq` = 1 first visible after the 5th non-reset edge. `vio_count` = 1, `vio_vec` = 0xFF, `vio_id` = 0.
- Capture and mask: ARMED, `chk_mask` = 0x04, one-cycle `chk_fire` = 0x14 → next cycle `irq` = 1, `vio_vec` = 0x10, `vio_id` = 4, `vio_count` = 1. Then `chk_fire` = 0x04 only → no change.
- Lost report: PEND, fire 0x01 for 3 cycles → `vio_count` += 3, `vio_lost` = 1, `vio_id` unchanged. Ack → `irq` = 0 and `vio_lost` = 0 next cycle, `armed` = 1.
- Reconfigure while pending: PEND, pulse `cfg_update`, later ack → state HOLD for 4 cycles with `armed` = 0. Fires during HOLD are not counted.
- Ack with simultaneous fire → `irq` = 0, `vio_lost` = 1, count incremented. A ARMED+`cfg_update`+fire cycle → no capture.
- Saturation: CNT_W = 2, 5 violating cycles → `vio_count` = 3. Then `rst` = 0 for one edge → all outputs 0.

Source files
------------

// File: rtl/assert_violation_collector.sv
// assert_violation_collector
// Merges the qualified outputs of the fabric assertion checkers into one
// latched violation report plus a level interrupt for the host. The first
// firing is captured with the index of its lowest-numbered checker. Every
// violating cycle is counted, saturating at the counter maximum. A sticky
// flag records violations that arrive while a report is still pending.
// After reset and after every fabric reconfiguration, checker outputs are
// ignored for a fixed hold-off window.

module assert_violation_collector #(
  parameter int NUM_CHK     = 8,
  parameter int ID_W        = 3,
  parameter int CNT_W       = 8,
  parameter int HOLDOFF_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CHK-1:0] chk_fire,
  input  logic [NUM_CHK-1:0] chk_mask,
  input  logic               cfg_update,
  input  logic               irq_ack,
  output logic               irq,
  output logic [ID_W-1:0]    vio_id,
  output logic [NUM_CHK-1:0] vio_vec,
  output logic [CNT_W-1:0]   vio_count,
  output logic               vio_lost,
  output logic               armed
);

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_ARMED = 2'd1,
    S_PEND  = 2'd2
  } state_t;

  localparam logic [7:0]       HO_LOAD = 8'(HOLDOFF_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state;
  logic [7:0]         ho_cnt;
  logic               ho_req;

  logic [NUM_CHK-1:0] eff;
  logic               eff_any;
  logic [ID_W-1:0]    eff_id;
  logic [CNT_W-1:0]   cnt_next;

  // Effective fire vector and the saturated next value of the counter.
  always_comb begin
    eff      = chk_fire & ~chk_mask;
    eff_any  = |eff;
    cnt_next = (vio_count == CNT_MAX) ? vio_count : vio_count + 1'b1;
  end

  // Lowest-numbered set bit of eff; scanning downwards lets the lowest index
  // overwrite any higher one.
  // NOTE: eff_id gets a default before the loop, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    eff_id = '0;
    for (int i = NUM_CHK - 1; i >= 0; i--) begin
      if (eff[i]) eff_id = ID_W'(i);
    end
  end

  // Control FSM with registered report outputs; armed is decoded from the next state.
  // NOTE: all state here uses non-blocking assignments, so every branch sees
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_HOLD;
      ho_cnt    <= HO_LOAD;
      ho_req    <= 1'b0;
      irq       <= 1'b0;
      vio_id    <= '0;
      vio_vec   <= '0;
      vio_count <= '0;
      vio_lost  <= 1'b0;
      armed     <= 1'b0;
    end else begin
      case (state)
        S_HOLD: begin
          if (cfg_update) begin
            ho_cnt <= HO_LOAD;
          end else if (ho_cnt == 8'd1) begin
            state <= S_ARMED;
            armed <= 1'b1;
          end else begin
            ho_cnt <= ho_cnt - 8'd1;
          end
        end

        S_ARMED: begin
          // A reconfiguration in the same cycle as a fire discards the fire.
          if (cfg_update) begin
            state  <= S_HOLD;
            ho_cnt <= HO_LOAD;
            armed  <= 1'b0;
          end else if (eff_any) begin
            vio_vec   <= eff;
            vio_id    <= eff_id;
            vio_count <= cnt_next;
            irq       <= 1'b1;
            state     <= S_PEND;
            armed     <= 1'b0;
          end
        end

        S_PEND: begin
          if (eff_any) vio_count <= cnt_next;
          if (irq_ack) begin
            irq      <= 1'b0;
            // A fire in the ack cycle still counts as a lost report.
            vio_lost <= eff_any;
            ho_req   <= 1'b0;
            if (ho_req || cfg_update) begin
              state  <= S_HOLD;
              ho_cnt <= HO_LOAD;
              armed  <= 1'b0;
            end else begin
              state <= S_ARMED;
              armed <= 1'b1;
            end
          end else begin
            if (eff_any)    vio_lost <= 1'b1;
            // Defer the hold-off until the pending report is acknowledged.
            if (cfg_update) ho_req   <= 1'b1;
          end
        end

        default: begin
          state  <= S_HOLD;
          ho_cnt <= HO_LOAD;
          armed  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_assert_violation_collector.sv
// Bench for assert_violation_collector. A behavioural model predicts the
// outputs for every driven cycle. The predictions are queued and then
// compared after the edge. A second instance with a 2-bit counter shares
// the same stimulus and exercises counter saturation.

module tb_assert_violation_collector;

  localparam int HO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] chk_fire;
  logic [7:0] chk_mask;
  logic       cfg_update;
  logic       irq_ack;

  logic       irq, vio_lost, armed;
  logic [2:0] vio_id;
  logic [7:0] vio_vec;
  logic [7:0] vio_count;

  logic       irq2, vio_lost2, armed2;
  logic [2:0] vio_id2;
  logic [7:0] vio_vec2;
  logic [1:0] vio_count2;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct packed {
    logic       irq;
    logic [2:0] id;
    logic [7:0] vec;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    logic       lost;
    logic       armed;
  } exp_t;

  exp_t exp_q[$];

  // Model state.
  int         m_state;  // 0 hold, 1 armed, 2 pending
  int         m_ho;
  bit         m_req;
  exp_t       m;

  always #5 clk = ~clk;

  assert_violation_collector #(
    .NUM_CHK(8), .ID_W(3), .CNT_W(8), .HOLDOFF_CYC(HO)
  ) dut (
    .clk(clk), .rst(rst), .chk_fire(chk_fire), .chk_mask(chk_mask),
    .cfg_update(cfg_update), .irq_ack(irq_ack), .irq(irq), .vio_id(vio_id),
    .vio_vec(vio_vec), .vio_count(vio_count), .vio_lost(vio_lost), .armed(armed)
  );

  assert_violation_collector #(
    .NUM_CHK(8), .ID_W(3), .CNT_W(2), .HOLDOFF_CYC(HO)
  ) dut_sat (
    .clk(clk), .rst(rst), .chk_fire(chk_fire), .chk_mask(chk_mask),
    .cfg_update(cfg_update), .irq_ack(irq_ack), .irq(irq2), .vio_id(vio_id2),
    .vio_vec(vio_vec2), .vio_count(vio_count2), .vio_lost(vio_lost2), .armed(armed2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Predict the outputs after the coming edge from the driven inputs.
  task automatic model_step(input bit r, input logic [7:0] fire, input logic [7:0] mask,
                            input bit cfg, input bit ack);
    logic [7:0] eff;
    bit         v;
    bit         found;
    eff = fire & ~mask;
    v   = (eff != 8'h00);
    if (!r) begin
      m_state = 0; m_ho = HO; m_req = 0;
      m = '0;
    end else begin
      case (m_state)
        0: begin
          if (cfg) m_ho = HO;
          else begin
            m_ho = m_ho - 1;
            if (m_ho == 0) m_state = 1;
          end
        end
        1: begin
          if (cfg) begin
            m_state = 0; m_ho = HO;
          end else if (v) begin
            m.vec = eff;
            found = 0;
            for (int i = 0; i < 8; i++)
              if (eff[i] && !found) begin m.id = 3'(i); found = 1; end
            if (m.cnt != 8'hFF) m.cnt = m.cnt + 8'd1;
            if (m.cnt2 != 2'd3) m.cnt2 = m.cnt2 + 2'd1;
            m.irq = 1; m_state = 2;
          end
        end
        default: begin
          if (v) begin
            if (m.cnt != 8'hFF) m.cnt = m.cnt + 8'd1;
            if (m.cnt2 != 2'd3) m.cnt2 = m.cnt2 + 2'd1;
          end
          if (ack) begin
            m.irq  = 0;
            m.lost = v;
            m_state = (m_req || cfg) ? 0 : 1;
            if (m_state == 0) m_ho = HO;
            m_req = 0;
          end else begin
            if (v)   m.lost = 1;
            if (cfg) m_req  = 1;
          end
        end
      endcase
      m.armed = (m_state == 1);
    end
  endtask

  // Drive one cycle, queue the prediction, then compare after the edge.
  task automatic cyc(input bit r, input logic [7:0] fire, input logic [7:0] mask,
                     input bit cfg, input bit ack);
    exp_t e;
    rst = r; chk_fire = fire; chk_mask = mask; cfg_update = cfg; irq_ack = ack;
    model_step(r, fire, mask, cfg, ack);
    exp_q.push_back(m);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("irq",       32'(irq),        32'(e.irq));
    check("vio_id",    32'(vio_id),     32'(e.id));
    check("vio_vec",   32'(vio_vec),    32'(e.vec));
    check("vio_count", 32'(vio_count),  32'(e.cnt));
    check("sat_count", 32'(vio_count2), 32'(e.cnt2));
    check("vio_lost",  32'(vio_lost),   32'(e.lost));
    check("armed",     32'(armed),      32'(e.armed));
  endtask

  initial begin
    rst = 1'b0; chk_fire = '0; chk_mask = '0; cfg_update = 1'b0; irq_ack = 1'b0;
    m_state = 0; m_ho = HO; m_req = 0; m = '0;
    #2;

    // Reset state.
    cyc(0, 8'h00, 8'h00, 0, 0);
    cyc(0, 8'h00, 8'h00, 0, 0);
    check("rst_all", {vio_count, vio_vec, 5'(vio_id), irq, vio_lost, armed}, 32'h0);

    // Hold-off: fires held from release; capture on the 5th non-reset edge.
    for (int i = 0; i < HO; i++) begin
      cyc(1, 8'hFF, 8'h00, 0, 0);
      check("ho_no_irq", 32'(irq), 32'h0);
    end
    check("ho_armed", 32'(armed), 32'h1);
    cyc(1, 8'hFF, 8'h00, 0, 0);
    check("ho_irq", {vio_count, vio_vec, 7'(vio_id), irq}, {8'd1, 8'hFF, 7'd0, 1'b1});

    // Capture and mask from a fresh reset.
    cyc(0, 8'h00, 8'h00, 0, 0);
    for (int i = 0; i < HO; i++) cyc(1, 8'h00, 8'h00, 0, 0);
    cyc(1, 8'h14, 8'h04, 0, 0);
    check("mask_cap", {vio_count, vio_vec, 7'(vio_id), irq}, {8'd1, 8'h10, 7'd4, 1'b1});
    cyc(1, 8'h04, 8'h04, 0, 0);
    check("mask_nochg", {vio_count, 7'(vio_lost), vio_lost}, {8'd1, 8'd0});

    // Lost reports while pending, then ack back to ARMED.
    for (int i = 0; i < 3; i++) cyc(1, 8'h01, 8'h04, 0, 0);
    check("lost_cnt", {vio_count, 7'(vio_id), vio_lost}, {8'd4, 7'd4, 1'b1});
    cyc(1, 8'h00, 8'h04, 0, 1);
    check("ack_clr", {irq, vio_lost, armed}, 3'b001);

    // Reconfigure while pending: ack leads to a full hold-off window.
    cyc(1, 8'h02, 8'h00, 0, 0);
    cyc(1, 8'h00, 8'h00, 1, 0);
    cyc(1, 8'h00, 8'h00, 0, 0);
    check("cfg_keep", {7'(vio_id), irq}, {7'd1, 1'b1});
    cyc(1, 8'h00, 8'h00, 0, 1);
    for (int i = 0; i < HO; i++) begin
      check("hold_armed", 32'(armed), 32'h0);
      cyc(1, 8'hFF, 8'h00, 0, 0);
    end
    check("hold_nocnt", {vio_count, irq, armed}, {8'd5, 1'b0, 1'b1});

    // Ack with simultaneous fire; then ARMED + cfg_update + fire.
    cyc(1, 8'h08, 8'h00, 0, 0);
    cyc(1, 8'h01, 8'h00, 0, 1);
    check("ack_fire", {vio_count, 7'(vio_id), irq, vio_lost}, {8'd7, 7'd3, 1'b0, 1'b1});
    cyc(1, 8'h20, 8'h00, 1, 0);
    check("cfg_wins", {vio_count, irq, armed}, {8'd7, 1'b0, 1'b0});
    for (int i = 0; i < HO; i++) cyc(1, 8'h00, 8'h00, 0, 0);

    // Saturation of the 2-bit counter, then reset mid-pending.
    cyc(0, 8'h00, 8'h00, 0, 0);
    for (int i = 0; i < HO; i++) cyc(1, 8'h00, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 8'h40, 8'h00, 0, 0);
    check("sat3", {vio_count2, vio_count}, {2'd3, 8'd5});
    cyc(0, 8'h40, 8'h00, 0, 0);
    check("rst_pend", {vio_count, vio_vec, 5'(vio_id), irq, vio_lost, armed}, 32'h0);
    check("rst_sat", 32'(vio_count2), 32'h0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 63) != 0),
          ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
          8'($urandom) & 8'($urandom),
          ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
